// File: rtl/conv_encoder_k3_if.sv
// Stream bundle for the K=3 rate-1/2 convolutional encoder.
// Input side: i_bit/i_valid/o_ready. Output side: o_sym/o_valid/i_ready.
// Optional macro CONV_ENC_LAST_EN adds the o_last frame marker.
interface conv_encoder_k3_if;
    logic       i_bit;
    logic       i_valid;
    logic       o_ready;
    logic [1:0] o_sym;
    logic       o_valid;
    logic       i_ready;
`ifdef CONV_ENC_LAST_EN
    logic       o_last;

    modport slave  (input  i_bit, i_valid, i_ready,
                    output o_ready, o_sym, o_valid, o_last);
    modport master (output i_bit, i_valid, i_ready,
                    input  o_ready, o_sym, o_valid, o_last);
`else
    modport slave  (input  i_bit, i_valid, i_ready,
                    output o_ready, o_sym, o_valid);
    modport master (output i_bit, i_valid, i_ready,
                    input  o_ready, o_sym, o_valid);
`endif
endinterface

// File: rtl/conv_encoder_k3.sv
// Rate-1/2, K=3 convolutional encoder (G0=7, G1=5 octal), 4-state trellis.
// Encodes FRAME_LEN info bits per frame and appends two zero tail bits so
// every frame ends in state 00 for the decoder's traceback.
// Optional macro CONV_ENC_LAST_EN: adds o_last, high with the final tail symbol.
module conv_encoder_k3 #(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    conv_encoder_k3_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_TAIL = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_tail;
    logic             w_tail_nxt;
    logic [1:0]       r_sr;
    logic [1:0]       r_sym;
    logic             r_valid;
`ifdef CONV_ENC_LAST_EN
    logic             r_last;
    logic             w_last_nxt;
`endif

    logic w_slot_free;
    logic w_ready;
    logic w_xfer;
    logic w_tail_load;
    logic w_load;
    logic w_u;
    logic w_c0;
    logic w_c1;

    // The output slot can take a new symbol when empty or being drained now.
    assign w_slot_free = !r_valid || bus.i_ready;
    assign w_ready     = w_slot_free && (r_state == S_IDLE || r_state == S_DATA);
    assign w_xfer      = bus.i_valid && w_ready;
    assign w_tail_load = (r_state == S_TAIL) && w_slot_free;
    assign w_load      = w_xfer || w_tail_load;

    // Tail cycles shift in zeros; r_sr[1]=u(n-1), r_sr[0]=u(n-2).
    assign w_u  = w_xfer & bus.i_bit;
    assign w_c0 = w_u ^ r_sr[1] ^ r_sr[0];
    assign w_c1 = w_u ^ r_sr[0];

    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // Next-state logic: count info bits, then emit exactly two tail symbols.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tail_nxt  = r_tail;
`ifdef CONV_ENC_LAST_EN
        w_last_nxt  = 1'b0;
`endif
        case (r_state)
            S_IDLE, S_DATA: begin
                if (w_xfer) begin
                    w_cnt_nxt  = w_cnt_inc;
                    w_tail_nxt = 1'b0;
                    if (w_cnt_inc == CNT_W'(FRAME_LEN)) begin
                        w_state_nxt = S_TAIL;
                    end else begin
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_TAIL: begin
                if (w_slot_free) begin
                    if (r_tail) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                        w_tail_nxt  = 1'b0;
`ifdef CONV_ENC_LAST_EN
                        w_last_nxt  = 1'b1;
`endif
                    end else begin
                        w_tail_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
                w_tail_nxt  = 1'b0;
            end
        endcase
    end

    // FSM state, info-bit counter and tail counter registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_tail  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tail  <= w_tail_nxt;
        end
    end

    // Encoder shift register advances on every info or tail symbol load.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sr <= 2'b00;
        end else if (w_load) begin
            r_sr <= {w_u, r_sr[1]};
        end
    end

    // Single registered output slot, held while downstream stalls.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sym   <= 2'b00;
            r_valid <= 1'b0;
`ifdef CONV_ENC_LAST_EN
            r_last  <= 1'b0;
`endif
        end else if (w_load) begin
            r_sym   <= {w_c0, w_c1};
            r_valid <= 1'b1;
`ifdef CONV_ENC_LAST_EN
            r_last  <= w_last_nxt;
`endif
        end else if (bus.i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.o_ready = w_ready;
    assign bus.o_sym   = r_sym;
    assign bus.o_valid = r_valid;
`ifdef CONV_ENC_LAST_EN
    assign bus.o_last  = r_last;
`endif

endmodule
